// File: rtl/octant_ratio_unit.sv
// Octant classifier and min/max ratio front end for the atan datapath.
// Classifies a signed complex sample into octants and computes floor(min*2^FRAC/max) using a bit-serial divider.
module octant_ratio_unit #(
  parameter int W     = 8,
  parameter int FRAC  = 7,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      real_i,
  input  logic [W-1:0]      imag_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC:0]     ratio_o,
  output logic [2:0]        octant_o,
  output logic              zero_o,
  output logic [TAG_W-1:0]  tag_o
);

  localparam int CW = (FRAC < 1) ? 1 : $clog2(FRAC + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAC);
  localparam logic [W-1:0]  ONE_W = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       re_q, re_d, im_q, im_d;
  logic [TAG_W-1:0]   tag_in_q, tag_in_d;
  logic [W-1:0]       min_q, min_d, max_q, max_d;
  logic [W:0]         rem_q, rem_d;
  logic [FRAC:0]      quot_q, quot_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [FRAC:0]      ratio_q, ratio_d;
  logic [2:0]         octant_q, octant_d;
  logic               zero_q, zero_d;
  logic [TAG_W-1:0]   tag_out_q, tag_out_d;

  logic               re_neg, im_neg, swap;
  logic [W-1:0]       abs_re, abs_im;
  logic [W:0]         trial, trial_sub;
  logic               ge;
  logic [FRAC:0]      quot_next;

  // Magnitudes are W-bit unsigned, so -2^(W-1) maps to 2^(W-1) exactly.
  assign re_neg = re_q[W-1];
  assign im_neg = im_q[W-1];
  assign abs_re = re_neg ? (~re_q + ONE_W) : re_q;
  assign abs_im = im_neg ? (~im_q + ONE_W) : im_q;
  assign swap   = (abs_im > abs_re);

  // First iteration consumes min directly: quotient bits above 2^FRAC are always zero since min <= max.
  assign trial     = (cnt_q == '0) ? {1'b0, min_q} : {rem_q[W-1:0], 1'b0};
  assign ge        = (trial >= {1'b0, max_q});
  assign trial_sub = trial - {1'b0, max_q};
  assign quot_next = {quot_q[FRAC-1:0], ge};

  always_comb begin
    state_d   = state_q;
    re_d      = re_q;
    im_d      = im_q;
    tag_in_d  = tag_in_q;
    min_d     = min_q;
    max_d     = max_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    ratio_d   = ratio_q;
    octant_d  = octant_q;
    zero_d    = zero_q;
    tag_out_d = tag_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          re_d     = real_i;
          im_d     = imag_i;
          tag_in_d = tag_i;
          state_d  = PREP;
        end
      end
      PREP: begin
        tag_out_d = tag_in_q;
        min_d     = swap ? abs_re : abs_im;
        max_d     = swap ? abs_im : abs_re;
        if ((re_q == '0) && (im_q == '0)) begin
          zero_d   = 1'b1;
          ratio_d  = '0;
          octant_d = 3'b000;
          state_d  = DONE;
        end else begin
          zero_d   = 1'b0;
          octant_d = {swap, im_neg, re_neg};
          rem_d    = '0;
          quot_d   = '0;
          cnt_d    = '0;
          state_d  = DIV;
        end
      end
      DIV: begin
        rem_d  = ge ? trial_sub : trial;
        quot_d = quot_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          ratio_d = quot_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      re_q      <= '0;
      im_q      <= '0;
      tag_in_q  <= '0;
      min_q     <= '0;
      max_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      ratio_q   <= '0;
      octant_q  <= '0;
      zero_q    <= 1'b0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      re_q      <= re_d;
      im_q      <= im_d;
      tag_in_q  <= tag_in_d;
      min_q     <= min_d;
      max_q     <= max_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
      ratio_q   <= ratio_d;
      octant_q  <= octant_d;
      zero_q    <= zero_d;
      tag_out_q <= tag_out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ratio_o   = ratio_q;
  assign octant_o  = octant_q;
  assign zero_o    = zero_q;
  assign tag_o     = tag_out_q;

endmodule
